// File: rtl/alu_sequencer_pkg.sv
// Shared constants and types for the ALU sequencer: ALU control codes,
// alu_op / funct encodings, FSM states and the response payload.
package alu_sequencer_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned CTRL_W  = 3;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned CNT_W   = 4;

  localparam logic [WORD_W-1:0] WORD_ZERO = '0;

  // Control codes understood by the downstream combinational ALU
  typedef enum logic [CTRL_W-1:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_OFF = 3'b011,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_e;

  // Operation class supplied by the datapath controller
  localparam logic [OP_W-1:0] OP_ADD   = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB   = 2'b01;
  localparam logic [OP_W-1:0] OP_RTYPE = 2'b10;

  // R-type function field values
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  // Captured response returned to the consumer
  typedef struct packed {
    logic [WORD_W-1:0] y;
    logic              zero;
    logic              err;
  } rsp_t;

endpackage

// File: rtl/alu_ctrl_decoder.sv
// Combinational decode of (alu_op, funct) into an ALU control code plus an
// illegal-request flag. Illegal requests always map to ALU_OFF.
module alu_ctrl_decoder
  import alu_sequencer_pkg::*;
(
  input  logic [OP_W-1:0]    alu_op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output alu_ctrl_e          ctrl_c,
  output logic               illegal_c
);

  // Decode table; anything not listed stays OFF and illegal
  always_comb begin
    ctrl_c    = ALU_OFF;
    illegal_c = 1'b1;
    case (alu_op_i)
      OP_ADD: begin
        ctrl_c    = ALU_ADD;
        illegal_c = 1'b0;
      end
      OP_SUB: begin
        ctrl_c    = ALU_SUB;
        illegal_c = 1'b0;
      end
      OP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: begin
            ctrl_c    = ALU_ADD;
            illegal_c = 1'b0;
          end
          FUNCT_SUB: begin
            ctrl_c    = ALU_SUB;
            illegal_c = 1'b0;
          end
          FUNCT_AND: begin
            ctrl_c    = ALU_AND;
            illegal_c = 1'b0;
          end
          FUNCT_OR: begin
            ctrl_c    = ALU_OR;
            illegal_c = 1'b0;
          end
          FUNCT_SLT: begin
            ctrl_c    = ALU_SLT;
            illegal_c = 1'b0;
          end
          default: begin
            ctrl_c    = ALU_OFF;
            illegal_c = 1'b1;
          end
        endcase
      end
      default: begin
        ctrl_c    = ALU_OFF;
        illegal_c = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_sequencer.sv
// Drives the external combinational ALU: accepts a request, holds operands and
// control stable for EXEC_CYCLES cycles, captures y/zero and returns them over
// a valid/ready response port. Back-to-back requests are accepted in RESP.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [OP_W-1:0]     req_alu_op,
  input  logic [FUNCT_W-1:0]  req_funct,
  input  logic [WORD_W-1:0]   req_a,
  input  logic [WORD_W-1:0]   req_b,
  output logic [WORD_W-1:0]   alu_a,
  output logic [WORD_W-1:0]   alu_b,
  output logic [CTRL_W-1:0]   alu_ctrl,
  input  logic [WORD_W-1:0]   alu_y,
  input  logic                alu_zero,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WORD_W-1:0]   rsp_y,
  output logic                rsp_zero,
  output logic                rsp_err
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EXEC_CYCLES - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  alu_ctrl_e         ctrl_q, ctrl_d;
  logic              illegal_q, illegal_d;
  logic              rsp_valid_q, rsp_valid_d;
  rsp_t              rsp_q, rsp_d;

  alu_ctrl_e         dec_ctrl_c;
  logic              dec_illegal_c;
  logic              req_ready_c;
  logic              accept_c;

  alu_ctrl_decoder u_dec (
    .alu_op_i  (req_alu_op),
    .funct_i   (req_funct),
    .ctrl_c    (dec_ctrl_c),
    .illegal_c (dec_illegal_c)
  );

  // Ready in IDLE, or in RESP when the pending response is being taken
  assign req_ready_c = (state_q == ST_IDLE) ||
                       ((state_q == ST_RESP) && rsp_ready);
  assign accept_c    = req_valid && req_ready_c;

  // Next-state, counter, operand latch and response capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    ctrl_d      = ctrl_q;
    illegal_d   = illegal_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;

    case (state_q)
      ST_IDLE: begin
        ctrl_d = ALU_OFF;
      end
      ST_EXEC: begin
        if (cnt_q == '0) begin
          // ALU output is undriven for illegal ops, so substitute zeros
          rsp_d.y     = illegal_q ? WORD_ZERO : alu_y;
          rsp_d.zero  = illegal_q ? 1'b0 : alu_zero;
          rsp_d.err   = illegal_q;
          rsp_valid_d = 1'b1;
          ctrl_d      = ALU_OFF;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        ctrl_d  = ALU_OFF;
        state_d = ST_IDLE;
      end
    endcase

    // A new request (from IDLE or same-cycle from RESP) starts execution
    if (accept_c) begin
      a_d       = req_a;
      b_d       = req_b;
      ctrl_d    = dec_ctrl_c;
      illegal_d = dec_illegal_c;
      cnt_d     = CNT_LOAD;
      rsp_d.err = 1'b0;
      state_d   = ST_EXEC;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      a_q         <= WORD_ZERO;
      b_q         <= WORD_ZERO;
      ctrl_q      <= ALU_OFF;
      illegal_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      ctrl_q      <= ctrl_d;
      illegal_q   <= illegal_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
    end
  end

  assign req_ready = req_ready_c;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_ctrl  = ctrl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_q.y;
  assign rsp_zero  = rsp_q.zero;
  assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: scoreboard fed from a behavioural model of the
// request semantics, monitor compares on each response handshake.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  typedef struct {
    logic [31:0] y;
    logic        zero;
    logic        err;
  } exp_t;

  logic clk;
  logic rst, rst4;

  // Main instance (EXEC_CYCLES=1)
  logic        req_valid, req_ready;
  logic [1:0]  req_alu_op;
  logic [5:0]  req_funct;
  logic [31:0] req_a, req_b, alu_a, alu_b, alu_y, rsp_y;
  logic [2:0]  alu_ctrl;
  logic        alu_zero, rsp_valid, rsp_ready, rsp_zero, rsp_err;

  // Second instance (EXEC_CYCLES=4) for multi-cycle and mid-op reset
  logic        d4_req_valid, d4_req_ready;
  logic [1:0]  d4_req_alu_op;
  logic [5:0]  d4_req_funct;
  logic [31:0] d4_req_a, d4_req_b, d4_alu_a, d4_alu_b, d4_alu_y, d4_rsp_y;
  logic [2:0]  d4_alu_ctrl;
  logic        d4_alu_zero, d4_rsp_valid, d4_rsp_ready, d4_rsp_zero, d4_rsp_err;

  int   checks;
  int   failures;
  exp_t sb_q[$];
  bit   rand_rdy;
  bit   forced_rdy;

  alu_sequencer #(.EXEC_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_alu_op(req_alu_op), .req_funct(req_funct),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_y(alu_y), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  alu_sequencer #(.EXEC_CYCLES(4)) dut4 (
    .clk(clk), .rst(rst4),
    .req_valid(d4_req_valid), .req_ready(d4_req_ready),
    .req_alu_op(d4_req_alu_op), .req_funct(d4_req_funct),
    .req_a(d4_req_a), .req_b(d4_req_b),
    .alu_a(d4_alu_a), .alu_b(d4_alu_b), .alu_ctrl(d4_alu_ctrl),
    .alu_y(d4_alu_y), .alu_zero(d4_alu_zero),
    .rsp_valid(d4_rsp_valid), .rsp_ready(d4_rsp_ready),
    .rsp_y(d4_rsp_y), .rsp_zero(d4_rsp_zero), .rsp_err(d4_rsp_err)
  );

  // Model of the external combinational ALU; garbage output when OFF
  function automatic logic [32:0] alu_model(logic [2:0] c, logic [31:0] a, logic [31:0] b);
    logic [31:0] y;
    case (c)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return {1'b1, 32'hDEADBEEF};
    endcase
    return {(y == 32'd0), y};
  endfunction

  assign {alu_zero, alu_y}       = alu_model(alu_ctrl, alu_a, alu_b);
  assign {d4_alu_zero, d4_alu_y} = alu_model(d4_alu_ctrl, d4_alu_a, d4_alu_b);

  // Reference semantics of a request
  function automatic exp_t ref_model(logic [1:0] op, logic [5:0] f, logic [31:0] a, logic [31:0] b);
    exp_t e;
    e.y = 32'd0; e.zero = 1'b0; e.err = 1'b0;
    case (op)
      2'b00: e.y = a + b;
      2'b01: e.y = a - b;
      2'b10: begin
        case (f)
          6'h20:   e.y = a + b;
          6'h22:   e.y = a - b;
          6'h24:   e.y = a & b;
          6'h25:   e.y = a | b;
          6'h2A:   e.y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          default: e.err = 1'b1;
        endcase
      end
      default: e.err = 1'b1;
    endcase
    if (!e.err) e.zero = (e.y == 32'd0);
    return e;
  endfunction

  // Control code the ALU must see while executing a request
  function automatic logic [2:0] exp_ctrl(logic [1:0] op, logic [5:0] f);
    case (op)
      2'b00: return ALU_ADD;
      2'b01: return ALU_SUB;
      2'b10: begin
        case (f)
          6'h20:   return ALU_ADD;
          6'h22:   return ALU_SUB;
          6'h24:   return ALU_AND;
          6'h25:   return ALU_OR;
          6'h2A:   return ALU_SLT;
          default: return ALU_OFF;
        endcase
      end
      default: return ALU_OFF;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request on the main instance; called and returns at posedge+1
  task automatic issue(input logic [1:0] op, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int t;
    bit ok;
    t = 0; ok = 0;
    req_valid = 1'b1; req_alu_op = op; req_funct = f; req_a = a; req_b = b;
    while (!ok && t < 50) begin
      @(negedge clk);
      if (req_ready) ok = 1;
      else begin
        @(posedge clk); #1;
        t++;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    sb_q.push_back(ref_model(op, f, a, b));
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("exec_ctrl", 32'(alu_ctrl), 32'(exp_ctrl(op, f)));
    chk("exec_a", alu_a, a);
    chk("exec_b", alu_b, b);
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Response-ready driver: random backpressure or a forced level
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : forced_rdy;
    end
  end

  // Monitor: compare every handshaken response against the scoreboard
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("rsp_y", rsp_y, e.y);
          chk("rsp_zero", 32'(rsp_zero), 32'(e.zero));
          chk("rsp_err", 32'(rsp_err), 32'(e.err));
        end
      end
    end
  end

  initial begin
    logic [5:0] legal [5];
    logic [1:0] op;
    logic [5:0] f;
    logic [31:0] a, b;
    int t;
    legal = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    checks = 0; failures = 0;
    rand_rdy = 1'b0; forced_rdy = 1'b1;
    rst = 1'b1; rst4 = 1'b1;
    req_valid = 1'b0; req_alu_op = 2'b00; req_funct = 6'h00; req_a = 32'd0; req_b = 32'd0;
    d4_req_valid = 1'b0; d4_req_alu_op = 2'b00; d4_req_funct = 6'h00;
    d4_req_a = 32'd0; d4_req_b = 32'd0; d4_rsp_ready = 1'b1;

    // Reset
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; rst4 = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'(ALU_OFF));
    chk("rst_rsp_y", rsp_y, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst4_req_ready", 32'(d4_req_ready), 32'd1);
    @(posedge clk); #1;

    // Directed: SUB, zero flag, SLT signed cases, illegal ops
    issue(2'b10, 6'h22, 32'd41, 32'd8);
    issue(2'b10, 6'h22, 32'd8, 32'd8);
    issue(2'b10, 6'h2A, 32'hFFFFFFFD, 32'hFFFFFFFB);
    issue(2'b10, 6'h2A, 32'hFFFFFFFB, 32'hFFFFFFFD);
    issue(2'b10, 6'h2A, 32'd5, 32'hFFFFFFFF);
    issue(2'b10, 6'h00, 32'd1, 32'd2);
    issue(2'b11, 6'h20, 32'd3, 32'd4);
    issue(2'b00, 6'h3F, 32'hFFFFFFFF, 32'd1);

    // Backpressure then back-to-back accept in RESP
    idle(2);
    forced_rdy = 1'b0;
    issue(2'b00, 6'h00, 32'd10, 32'd20);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
      chk("hold_rsp_y", rsp_y, 32'd30);
      chk("hold_rsp_err", 32'(rsp_err), 32'd0);
      @(posedge clk); #1;
    end
    forced_rdy = 1'b1;
    issue(2'b00, 6'h00, 32'd2, 32'd3);

    // Randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      op = 2'($urandom_range(0, 3));
      f  = ($urandom_range(0, 4) != 0) ? legal[$urandom_range(0, 4)] : 6'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : 32'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      issue(op, f, a, b);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    rand_rdy = 1'b0; forced_rdy = 1'b1;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk); t++;
    end
    #1;
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    // EXEC_CYCLES=4: reset during second EXEC cycle drops the op
    d4_req_valid = 1'b1; d4_req_alu_op = 2'b00; d4_req_a = 32'd7; d4_req_b = 32'd9;
    @(negedge clk);
    chk("d4_accept", 32'(d4_req_ready), 32'd1);
    @(posedge clk); #1;
    d4_req_valid = 1'b0;
    @(negedge clk);
    chk("d4_exec1_ctrl", 32'(d4_alu_ctrl), 32'(ALU_ADD));
    @(posedge clk); #1;
    rst4 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("d4_dropped_rsp_valid", 32'(d4_rsp_valid), 32'd0);
      chk("d4_idle_ctrl", 32'(d4_alu_ctrl), 32'(ALU_OFF));
      chk("d4_idle_ready", 32'(d4_req_ready), 32'd1);
      @(posedge clk); #1;
    end

    // Following request completes after exactly 4 cycles
    d4_req_valid = 1'b1; d4_req_alu_op = 2'b00; d4_req_a = 32'd100; d4_req_b = 32'd23;
    @(negedge clk);
    chk("d4_accept2", 32'(d4_req_ready), 32'd1);
    @(posedge clk); #1;
    d4_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("d4_exec_ctrl", 32'(d4_alu_ctrl), 32'(ALU_ADD));
      chk("d4_exec_a", d4_alu_a, 32'd100);
      chk("d4_exec_rsp_valid", 32'(d4_rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("d4_rsp_valid", 32'(d4_rsp_valid), 32'd1);
    chk("d4_rsp_y", d4_rsp_y, 32'd123);
    chk("d4_rsp_zero", 32'(d4_rsp_zero), 32'd0);
    chk("d4_rsp_err", 32'(d4_rsp_err), 32'd0);
    chk("d4_resp_ctrl", 32'(d4_alu_ctrl), 32'(ALU_OFF));
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
